// File: rtl/masked_rmw_mem.sv
// masked_rmw_mem: single-clock RAM with one byte-masked write port and one read port.
// Partial writes merge into the stored word, so callers never need to pre-read.
//
// Parameters:
//   DATA_W      word width in bits (multiple of 8)
//   DEPTH       number of words (any positive value)
//   ADDR_W      address port width; the full address must be < DEPTH to hit storage
//   READ_LAT    0 = combinational read, 1 = registered read
//   WRITE_FIRST READ_LAT=1 only: same-address read during a write returns the merged word (1)
//               or the pre-write word (0)
//
// Ports:
//   clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   io_wr_en/addr/data  write strobe, word address, data
//   io_wr_mask          byte enables, bit i covers data bits [8i+7:8i]
//   io_rd_en            read strobe (used only when READ_LAT=1)
//   io_rd_addr          read word address
//   io_rd_data/valid    read data and valid; both forced to 0 while reset_n is low
module masked_rmw_mem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned READ_LAT    = 0,
  parameter int unsigned WRITE_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                io_wr_en,
  input  logic [ADDR_W-1:0]   io_wr_addr,
  input  logic [DATA_W-1:0]   io_wr_data,
  input  logic [DATA_W/8-1:0] io_wr_mask,
  input  logic                io_rd_en,
  input  logic [ADDR_W-1:0]   io_rd_addr,
  output logic [DATA_W-1:0]   io_rd_data,
  output logic                io_rd_valid
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_idx;
  logic            wr_hit;
  logic            rd_in_range;

  // Range is judged on the full address so aliases with upper bits set never hit storage.
  assign wr_idx      = io_wr_addr[IdxW-1:0];
  assign rd_idx      = io_rd_addr[IdxW-1:0];
  assign wr_hit      = io_wr_en && (io_wr_addr < DepthA);
  assign rd_in_range = io_rd_addr < DepthA;

  // Per-byte enables map straight onto byte-write RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (io_wr_mask[b]) begin
          mem[wr_idx][8*b +: 8] <= io_wr_data[8*b +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        mem[i][8*b +: 8] = 8'($random);
      end
    end
  end
`endif

  if (READ_LAT == 0) begin : g_comb_read
    logic unused_rd_en;
    assign unused_rd_en = io_rd_en;

    // A same-cycle write lands at the edge, so this cycle still shows the old word.
    assign io_rd_data  = (reset_n && rd_in_range) ? mem[rd_idx] : '0;
    assign io_rd_valid = reset_n;
  end else begin : g_reg_read
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] wr_merged;
    logic              collide;

    assign collide = wr_hit && io_rd_en && (io_wr_addr == io_rd_addr);

    always_comb begin
      wr_merged = mem[wr_idx];
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (io_wr_mask[b]) begin
          wr_merged[8*b +: 8] = io_wr_data[8*b +: 8];
        end
      end
    end

    always_comb begin
      rd_data_d = rd_data_q;
      if (io_rd_en) begin
        if (!rd_in_range) begin
          rd_data_d = '0;
        end else if (collide && (WRITE_FIRST != 0)) begin
          rd_data_d = wr_merged;
        end else begin
          rd_data_d = mem[rd_idx];
        end
      end
    end

    // Async reset clears the in-flight read; memory itself is untouched.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= io_rd_en;
      end
    end

    assign io_rd_data  = rd_data_q;
    assign io_rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_masked_rmw_mem.sv
module tb_masked_rmw_mem;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus for the write-first (a) and read-first (b) registered builds
  logic        ab_wr_en, ab_rd_en;
  logic [31:0] ab_wr_addr, ab_wr_data, ab_rd_addr;
  logic [3:0]  ab_wr_mask;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;

  // DEPTH=6, ADDR_W=40 registered build
  logic        c_wr_en, c_rd_en;
  logic [39:0] c_wr_addr, c_rd_addr;
  logic [31:0] c_wr_data, c_rd_data;
  logic [3:0]  c_wr_mask;
  logic        c_rd_valid;

  // DATA_W=64, DEPTH=16 combinational build
  logic        d_wr_en, d_rd_en;
  logic [31:0] d_wr_addr, d_rd_addr;
  logic [63:0] d_wr_data, d_rd_data;
  logic [7:0]  d_wr_mask;
  logic        d_rd_valid;

  masked_rmw_mem #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .READ_LAT(1), .WRITE_FIRST(1)) u_a (
    .clk(clk), .reset_n(reset_n), .io_wr_en(ab_wr_en), .io_wr_addr(ab_wr_addr),
    .io_wr_data(ab_wr_data), .io_wr_mask(ab_wr_mask), .io_rd_en(ab_rd_en),
    .io_rd_addr(ab_rd_addr), .io_rd_data(a_rd_data), .io_rd_valid(a_rd_valid));

  masked_rmw_mem #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .READ_LAT(1), .WRITE_FIRST(0)) u_b (
    .clk(clk), .reset_n(reset_n), .io_wr_en(ab_wr_en), .io_wr_addr(ab_wr_addr),
    .io_wr_data(ab_wr_data), .io_wr_mask(ab_wr_mask), .io_rd_en(ab_rd_en),
    .io_rd_addr(ab_rd_addr), .io_rd_data(b_rd_data), .io_rd_valid(b_rd_valid));

  masked_rmw_mem #(.DATA_W(32), .DEPTH(6), .ADDR_W(40), .READ_LAT(1), .WRITE_FIRST(1)) u_c (
    .clk(clk), .reset_n(reset_n), .io_wr_en(c_wr_en), .io_wr_addr(c_wr_addr),
    .io_wr_data(c_wr_data), .io_wr_mask(c_wr_mask), .io_rd_en(c_rd_en),
    .io_rd_addr(c_rd_addr), .io_rd_data(c_rd_data), .io_rd_valid(c_rd_valid));

  masked_rmw_mem #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .READ_LAT(0), .WRITE_FIRST(1)) u_d (
    .clk(clk), .reset_n(reset_n), .io_wr_en(d_wr_en), .io_wr_addr(d_wr_addr),
    .io_wr_data(d_wr_data), .io_wr_mask(d_wr_mask), .io_rd_en(d_rd_en),
    .io_rd_addr(d_rd_addr), .io_rd_data(d_rd_data), .io_rd_valid(d_rd_valid));

  // Reference contents: plain arrays updated by the byte-merge rule
  logic [31:0] ref_ab [8];
  logic [31:0] ref_c  [6];
  logic [63:0] ref_d  [16];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ab_wr_en = 0; ab_rd_en = 0; ab_wr_addr = 0; ab_wr_data = 0; ab_wr_mask = 0; ab_rd_addr = 0;
    c_wr_en = 0; c_rd_en = 0; c_wr_addr = 0; c_wr_data = 0; c_wr_mask = 0; c_rd_addr = 0;
    d_wr_en = 0; d_rd_en = 0; d_wr_addr = 0; d_wr_data = 0; d_wr_mask = 0; d_rd_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid got %0b want 0", a_rd_valid); end
    n_cmp++; if (a_rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_a_data got %h want 0", a_rd_data); end
    n_cmp++; if (b_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got %0b want 0", b_rd_valid); end
    n_cmp++; if (c_rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_c_data got %h want 0", c_rd_data); end
    n_cmp++; if (d_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_valid got %0b want 0", d_rd_valid); end
    n_cmp++; if (d_rd_data !== 64'h0) begin n_bad++; $display("FAIL reset_d_data got %h want 0", d_rd_data); end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    cyc();
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_a_valid got %0b want 0", a_rd_valid); end
    n_cmp++; if (d_rd_valid !== 1'b1) begin n_bad++; $display("FAIL post_reset_d_valid got %0b want 1", d_rd_valid); end
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++) begin
      ab_wr_en = (i < 8); ab_wr_addr = 32'(i); ab_wr_data = $urandom; ab_wr_mask = 4'hF;
      c_wr_en = (i < 6); c_wr_addr = 40'(i); c_wr_data = $urandom; c_wr_mask = 4'hF;
      d_wr_en = 1; d_wr_addr = 32'(i); d_wr_data = {$urandom, $urandom}; d_wr_mask = 8'hFF;
      cyc();
      if (i < 8) ref_ab[i] = ab_wr_data;
      if (i < 6) ref_c[i] = c_wr_data;
      ref_d[i] = d_wr_data;
    end
    idle();
    cyc();
  endtask

  task automatic test_full_write();
    ab_wr_en = 1; ab_wr_addr = 3; ab_wr_data = 32'hDEADBEEF; ab_wr_mask = 4'hF;
    cyc();
    ref_ab[3] = 32'hDEADBEEF;
    ab_wr_en = 0; ab_rd_en = 1; ab_rd_addr = 3;
    #1;
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_early got %0b want 0", a_rd_valid); end
    cyc();
    n_cmp++; if (a_rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_a_data got %h want deadbeef", a_rd_data); end
    n_cmp++; if (a_rd_valid !== 1'b1) begin n_bad++; $display("FAIL full_a_valid got %0b want 1", a_rd_valid); end
    n_cmp++; if (b_rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_b_data got %h want deadbeef", b_rd_data); end
    ab_rd_en = 0; ab_rd_addr = 4;
    cyc();
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL hold_a_valid got %0b want 0", a_rd_valid); end
    n_cmp++; if (a_rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_a_data got %h want deadbeef", a_rd_data); end
  endtask

  task automatic test_merge();
    ab_wr_en = 1; ab_wr_addr = 5; ab_wr_data = 32'h11223344; ab_wr_mask = 4'hF;
    cyc();
    ab_wr_data = 32'hAABBCCDD; ab_wr_mask = 4'h5;
    cyc();
    ab_wr_data = 32'hFFFFFFFF; ab_wr_mask = 4'h0;
    cyc();
    ref_ab[5] = 32'h11BB33DD;
    ab_wr_en = 0; ab_rd_en = 1; ab_rd_addr = 5;
    cyc();
    ab_rd_en = 0;
    n_cmp++; if (a_rd_data !== 32'h11BB33DD) begin n_bad++; $display("FAIL merge_a got %h want 11bb33dd", a_rd_data); end
    n_cmp++; if (b_rd_data !== 32'h11BB33DD) begin n_bad++; $display("FAIL merge_b got %h want 11bb33dd", b_rd_data); end
  endtask

  task automatic test_collision();
    ab_wr_en = 1; ab_wr_addr = 2; ab_wr_data = 32'h0; ab_wr_mask = 4'hF;
    cyc();
    ab_wr_data = 32'h12345678; ab_wr_mask = 4'h3; ab_rd_en = 1; ab_rd_addr = 2;
    cyc();
    ref_ab[2] = 32'h00005678;
    n_cmp++; if (a_rd_data !== 32'h00005678) begin n_bad++; $display("FAIL coll_wf1 got %h want 00005678", a_rd_data); end
    n_cmp++; if (b_rd_data !== 32'h00000000) begin n_bad++; $display("FAIL coll_wf0 got %h want 00000000", b_rd_data); end
    n_cmp++; if (b_rd_valid !== 1'b1) begin n_bad++; $display("FAIL coll_valid got %0b want 1", b_rd_valid); end
    ab_wr_en = 0;
    cyc();
    n_cmp++; if (a_rd_data !== 32'h00005678) begin n_bad++; $display("FAIL coll_next_a got %h want 00005678", a_rd_data); end
    n_cmp++; if (b_rd_data !== 32'h00005678) begin n_bad++; $display("FAIL coll_next_b got %h want 00005678", b_rd_data); end
    ab_rd_en = 0;
  endtask

  function automatic logic [31:0] pick_addr(input logic [31:0] same);
    int r;
    r = int'($urandom % 12);
    if (r < 8) return 32'(r);
    if (r == 8) return 32'(8 + $urandom % 4);
    if (r == 9) return (32'h1 << (3 + $urandom % 29)) | 32'($urandom % 8);
    return same;
  endfunction

  task automatic test_random();
    logic [31:0] exp_a, exp_b, pre, post;
    exp_a = 0; exp_b = 0;
    for (int i = 0; i < 300; i++) begin
      ab_wr_en = 1'($urandom % 2);
      ab_wr_addr = pick_addr(32'h0);
      ab_wr_data = $urandom;
      ab_wr_mask = 4'($urandom);
      ab_rd_en = (i == 0) ? 1'b1 : 1'($urandom % 2);
      ab_rd_addr = pick_addr(ab_wr_addr);
      pre = (ab_rd_addr < 8) ? ref_ab[ab_rd_addr[2:0]] : 32'h0;
      if (ab_wr_en && ab_wr_addr < 8)
        ref_ab[ab_wr_addr[2:0]] =
          32'(merge({32'h0, ref_ab[ab_wr_addr[2:0]]}, {32'h0, ab_wr_data}, {4'h0, ab_wr_mask}));
      post = (ab_rd_addr < 8) ? ref_ab[ab_rd_addr[2:0]] : 32'h0;
      if (ab_rd_en) begin exp_a = post; exp_b = pre; end
      cyc();
      n_cmp++; if (a_rd_data !== exp_a) begin n_bad++; $display("FAIL rand_a[%0d] got %h want %h", i, a_rd_data, exp_a); end
      n_cmp++; if (b_rd_data !== exp_b) begin n_bad++; $display("FAIL rand_b[%0d] got %h want %h", i, b_rd_data, exp_b); end
      n_cmp++; if (a_rd_valid !== ab_rd_en) begin n_bad++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, a_rd_valid, ab_rd_en); end
    end
    idle();
    cyc();
  endtask

  task automatic test_range();
    c_wr_en = 1; c_wr_mask = 4'hF; c_wr_addr = 40'd6; c_wr_data = 32'hCAFEF00D;
    cyc();
    c_wr_addr = 40'h01_0000_0002; c_wr_data = 32'h0BADBEEF;
    cyc();
    c_wr_en = 0; c_rd_en = 1;
    for (int i = 0; i < 6; i++) begin
      c_rd_addr = 40'(i);
      cyc();
      n_cmp++; if (c_rd_data !== ref_c[i]) begin n_bad++; $display("FAIL range_keep[%0d] got %h want %h", i, c_rd_data, ref_c[i]); end
    end
    c_rd_addr = 40'd7;
    cyc();
    n_cmp++; if (c_rd_data !== 32'h0) begin n_bad++; $display("FAIL range_oor_data got %h want 0", c_rd_data); end
    n_cmp++; if (c_rd_valid !== 1'b1) begin n_bad++; $display("FAIL range_oor_valid got %0b want 1", c_rd_valid); end
    c_rd_addr = 40'h01_0000_0002;
    cyc();
    n_cmp++; if (c_rd_data !== 32'h0) begin n_bad++; $display("FAIL range_alias got %h want 0", c_rd_data); end
    c_rd_en = 0;
  endtask

  task automatic test_reset_mid_read();
    ab_rd_en = 1; ab_rd_addr = 3;
    cyc();
    n_cmp++; if (a_rd_data !== ref_ab[3]) begin n_bad++; $display("FAIL pre_rst_data got %h want %h", a_rd_data, ref_ab[3]); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (a_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data got %h want 0", a_rd_data); end
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %0b want 0", a_rd_valid); end
    n_cmp++; if (b_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_b_valid got %0b want 0", b_rd_valid); end
    cyc();
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_valid got %0b want 0", a_rd_valid); end
    #2 reset_n = 1'b1;
    ab_rd_addr = 5;
    cyc();
    n_cmp++; if (a_rd_data !== ref_ab[5]) begin n_bad++; $display("FAIL rst_kept_data got %h want %h", a_rd_data, ref_ab[5]); end
    n_cmp++; if (a_rd_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_valid got %0b want 1", a_rd_valid); end
    ab_rd_en = 0;
  endtask

  task automatic test_lat0();
    logic [63:0] old15;
    old15 = ref_d[15];
    d_wr_en = 1; d_wr_addr = 15; d_wr_data = 64'h0102030405060708; d_wr_mask = 8'h81;
    d_rd_addr = 15;
    #1;
    n_cmp++; if (d_rd_data !== old15) begin n_bad++; $display("FAIL lat0_same_cycle got %h want %h", d_rd_data, old15); end
    cyc();
    d_wr_en = 0;
    ref_d[15] = {8'h01, old15[55:8], 8'h08};
    #1;
    n_cmp++; if (d_rd_data !== ref_d[15]) begin n_bad++; $display("FAIL lat0_next got %h want %h", d_rd_data, ref_d[15]); end
    for (int i = 0; i <= 16; i++) begin
      d_wr_en = (i < 16); d_wr_addr = 32'(i); d_wr_data = {$urandom, $urandom};
      d_wr_mask = 8'($urandom);
      d_rd_addr = (i > 0) ? 32'(i - 1) : 32'd0;
      #1;
      if (i > 0) begin
        n_cmp++; if (d_rd_data !== ref_d[i-1]) begin n_bad++; $display("FAIL lat0_stream[%0d] got %h want %h", i - 1, d_rd_data, ref_d[i-1]); end
      end
      cyc();
      if (i < 16) ref_d[i] = merge(ref_d[i], d_wr_data, d_wr_mask);
    end
    d_wr_en = 0; d_rd_addr = 32'd16;
    #1;
    n_cmp++; if (d_rd_data !== 64'h0) begin n_bad++; $display("FAIL lat0_oor_data got %h want 0", d_rd_data); end
    n_cmp++; if (d_rd_valid !== 1'b1) begin n_bad++; $display("FAIL lat0_oor_valid got %0b want 1", d_rd_valid); end
    d_rd_addr = 32'h8000_000F;
    #1;
    n_cmp++; if (d_rd_data !== 64'h0) begin n_bad++; $display("FAIL lat0_alias got %h want 0", d_rd_data); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_full_write();
    test_merge();
    test_collision();
    test_random();
    test_range();
    test_reset_mid_read();
    test_lat0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
